keypad_input: RTL and testbench

KEYPAD_INPUT -- requirements
Module: keypad_input

---
 rtl/keypad_input.sv | 203 ++++++++++++++++++++
 tb/tb_keypad_input.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_input.sv
// 4x5 matrix keypad scanner: synchronizes rows, scans columns, debounces per
// frame and queues confirmed key codes in a 2-entry FIFO for the controller.
module keypad_input #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_N    = 4,
  parameter int IC_N     = 5
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [4:0]      col_n,
  input  logic [3:0]      row_n,
  output logic [IC_N-1:0] in_cmd,
  input  logic            in_ack,
  output logic            overflow
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_N + 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       col_q;
  logic [4:0]       col_n_q;
  logic [1:0]       frame_cnt_q, frame_cnt_d;
  logic [4:0]       frame_key_q, frame_key_d;
  logic             dwell_end, frame_end;
  logic [2:0]       hits;
  logic [1:0]       row_idx, col_cnt;
  logic [2:0]       tot;
  logic [4:0]       key_this;

  state_t           state_q, state_d;
  logic [4:0]       cand_q, cand_d, push_key;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic [IC_N-1:0]  push_code;

  logic [IC_N-1:0]  head_q, head_d, tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
    end
  end

  assign dwell_end = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (col_q == 3'd4);

  // Per-column decode; any column with 2+ rows low already makes the frame MULTI.
  always_comb begin
    hits    = '0;
    row_idx = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        hits    = hits + 3'd1;
        row_idx = 2'(r);
      end
    end
    col_cnt     = (hits > 3'd1) ? 2'd2 : hits[1:0];
    tot         = {1'b0, frame_cnt_q} + {1'b0, col_cnt};
    frame_cnt_d = (tot > 3'd1) ? 2'd2 : tot[1:0];
    key_this    = {3'b000, row_idx} * 5'd5 + {2'b00, col_q};
    frame_key_d = (frame_cnt_q == 2'd0 && hits == 3'd1) ? key_this : frame_key_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q       <= '0;
      col_q       <= '0;
      col_n_q     <= 5'b11110;
      frame_cnt_q <= '0;
      frame_key_q <= '0;
    end else if (dwell_end) begin
      div_q       <= '0;
      col_q       <= frame_end ? 3'd0 : col_q + 3'd1;
      col_n_q     <= {col_n_q[3:0], col_n_q[4]};
      frame_cnt_q <= frame_end ? 2'd0 : frame_cnt_d;
      frame_key_q <= frame_end ? 5'd0 : frame_key_d;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign col_n = col_n_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame result: frame_cnt_d 0 = NONE, 1 = SINGLE(frame_key_d), 2 = MULTI.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_key = cand_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_cnt_d == 2'd1) begin
            cand_d = frame_key_d;
            if (DEB_N == 1) begin
              push     = 1'b1;
              push_key = frame_key_d;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (frame_cnt_d == 2'd1 && frame_key_d == cand_q) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEB_N)) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_cnt_d == 2'd0) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEB_N)) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_code = IC_N'(push_key) + IC_N'(1);
  assign pop       = in_ack && (occ_q != 2'd0);

  // Pop is applied first so a push into a full FIFO that is popping this cycle still lands.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) begin
        head_d = push_code;
        occ_d  = 2'd1;
      end else if (occ_d == 2'd1) begin
        tail_d = push_code;
        occ_d  = 2'd2;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_cmd   = (occ_q != 2'd0) ? head_q : '0;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_input.sv
// Self-checking bench for keypad_input: a keypad model answers the column
// drive, table vectors step whole frames, and acks are checked against a queue.
module tb_keypad_input;
  localparam int SCAN_DIV = 4;
  localparam int DEB_N    = 2;
  localparam int IC_N     = 5;
  localparam int FRAME    = 5 * SCAN_DIV;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      col_n;
  logic [3:0]      row_n;
  logic [IC_N-1:0] in_cmd;
  logic            in_ack = 1'b0;
  logic            overflow;

  logic [19:0] keys = '0;
  int          cyc;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_q[$];

  typedef struct packed {
    logic [19:0] keys;
    logic [7:0]  nf;
    logic [7:0]  push_code;
    logic [7:0]  exp_cmd;
    logic        exp_ovf;
    logic        ack;
    logic [7:0]  exp_after;
  } vec_t;

  vec_t vt [20];

  always #5 clk = ~clk;

  keypad_input #(.SCAN_DIV(SCAN_DIV), .DEB_N(DEB_N), .IC_N(IC_N)) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .in_cmd   (in_cmd),
    .in_ack   (in_ack),
    .overflow (overflow)
  );

  // Pressed key k = row*5+col pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r*5+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Cycles since reset release; a frame ends on every edge where cyc hits a multiple of FRAME.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (cyc % FRAME != 0) @(negedge clk);
    end
  endtask

  task automatic ack_now(input string nm);
    int e;
    e = 0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({nm, "_head_at_ack"}, 32'(in_cmd), e);
    in_ack = 1'b1;
    @(negedge clk);
    in_ack = 1'b0;
  endtask

  task automatic ack_at_frame_end(input string nm);
    while (cyc % FRAME != FRAME - 1) @(negedge clk);
    ack_now(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           keys                    nf  push cmd ovf ack after
    vt[0]  = '{20'd1 << 7,               1,  0,   0,  0,  0,  0};
    vt[1]  = '{20'd1 << 7,               1,  8,   8,  0,  0,  0};
    vt[2]  = '{20'd1 << 7,               2,  0,   8,  0,  1,  0};
    vt[3]  = '{20'd0,                    2,  0,   0,  0,  0,  0};
    vt[4]  = '{20'd1 << 0,               1,  0,   0,  0,  0,  0};
    vt[5]  = '{20'd0,                    1,  0,   0,  0,  0,  0};
    vt[6]  = '{20'd1 << 0,               1,  0,   0,  0,  0,  0};
    vt[7]  = '{20'd1 << 0,               1,  1,   1,  0,  1,  0};
    vt[8]  = '{20'd0,                    2,  0,   0,  0,  0,  0};
    vt[9]  = '{(20'd1 << 1) | (20'd1 << 19), 3, 0, 0, 0,  0,  0};
    vt[10] = '{(20'd1 << 2) | (20'd1 << 7),  2, 0, 0, 0,  0,  0};
    vt[11] = '{20'd0,                    1,  0,   0,  0,  0,  0};
    vt[12] = '{20'd1 << 3,               2,  4,   4,  0,  0,  0};
    vt[13] = '{20'd0,                    2,  0,   4,  0,  0,  0};
    vt[14] = '{20'd1 << 4,               2,  5,   4,  0,  0,  0};
    vt[15] = '{20'd0,                    2,  0,   4,  0,  0,  0};
    vt[16] = '{20'd1 << 5,               2,  0,   4,  1,  0,  0};
    vt[17] = '{20'd0,                    2,  0,   4,  1,  1,  5};
    vt[18] = '{20'd0,                    1,  0,   5,  1,  1,  0};
    vt[19] = '{20'd0,                    1,  0,   0,  1,  1,  0};

    repeat (3) @(negedge clk);
    check("reset_col_n", 32'(col_n), 32'h1E);
    check("reset_in_cmd", 32'(in_cmd), 0);
    check("reset_overflow", 32'(overflow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      keys = vt[i].keys;
      if (vt[i].push_code != 0) exp_q.push_back(int'(vt[i].push_code));
      frames(int'(vt[i].nf));
      check($sformatf("vec%0d_in_cmd", i), 32'(in_cmd), 32'(vt[i].exp_cmd));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].exp_ovf));
      if (vt[i].ack) begin
        ack_now($sformatf("vec%0d", i));
        check($sformatf("vec%0d_after_ack", i), 32'(in_cmd), 32'(vt[i].exp_after));
      end
    end

    // Reset in the middle of CONFIRM, asserted between clock edges.
    keys = 20'd1 << 7;
    frames(1);
    repeat (7) @(negedge clk);
    check("pre_reset_col_n", 32'(col_n), 32'h1D);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_col_n", 32'(col_n), 32'h1E);
    check("async_reset_in_cmd", 32'(in_cmd), 0);
    check("async_reset_overflow", 32'(overflow), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    frames(1);
    check("fresh_frame1_in_cmd", 32'(in_cmd), 0);
    exp_q.push_back(8);
    frames(1);
    check("fresh_frame2_in_cmd", 32'(in_cmd), 8);
    keys = '0;
    ack_now("after_reset");
    check("after_reset_ack_in_cmd", 32'(in_cmd), 0);
    frames(2);

    // Press latency: code shows only after the frame-end edge of the DEB_N-th frame.
    keys = 20'd1 << 10;
    exp_q.push_back(11);
    frames(1);
    while (cyc % FRAME != FRAME - 1) @(negedge clk);
    check("latency_before_edge", 32'(in_cmd), 0);
    @(negedge clk);
    check("latency_after_edge", 32'(in_cmd), 11);
    keys = '0;
    frames(2);

    // Ack coincides with a push while one entry is queued.
    keys = 20'd1 << 12;
    frames(1);
    exp_q.push_back(13);
    ack_at_frame_end("sim_pop_occ1");
    check("sim_occ1_in_cmd", 32'(in_cmd), 13);
    check("sim_occ1_overflow", 32'(overflow), 0);
    keys = '0;
    frames(2);
    keys = 20'd1 << 14;
    exp_q.push_back(15);
    frames(2);
    check("full_head_in_cmd", 32'(in_cmd), 13);
    keys = '0;
    frames(2);

    // Ack coincides with a push while the FIFO is full.
    keys = 20'd1 << 15;
    frames(1);
    exp_q.push_back(16);
    ack_at_frame_end("sim_pop_full");
    check("sim_full_in_cmd", 32'(in_cmd), 15);
    check("sim_full_overflow", 32'(overflow), 0);
    keys = '0;
    ack_now("drain1");
    check("drain1_in_cmd", 32'(in_cmd), 16);
    ack_now("drain2");
    check("drain2_in_cmd", 32'(in_cmd), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("final_overflow", 32'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
